// File: rtl/sopc_sysid_ext.sv
// rtl/sopc_sysid_ext.sv - system ID slave with uptime counter, scratch and control registers
module sopc_sysid_ext #(
  parameter logic [31:0] SYSID_VALUE  = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP    = 32'd1523851750,
  parameter int          READ_LATENCY = 1,
  parameter int          CNT_W        = 64
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             read,
  input  logic             write,
  input  logic [31:0]      writedata,
  input  logic [3:0]       byteenable,
  output logic [31:0]      readdata,
  output logic             readdatavalid,
  output logic [CNT_W-1:0] uptime
);

  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-33:0] snap;
  logic [31:0]       scratch0;
  logic [31:0]       scratch1;
  logic              run;

  logic [31:0]             data_pipe [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_pipe;

  logic        wr_en;
  logic        clear;
  logic [31:0] hi_word;
  logic [31:0] rd_word;

  // A simultaneous read wins; the write is dropped entirely.
  assign wr_en = write & ~read;
  assign clear = wr_en & (address == 3'd6) & byteenable[0] & writedata[1];

  always_comb begin
    hi_word = '0;
    hi_word[CNT_W-33:0] = snap;
    rd_word = '0;
    case (address)
      3'd0: rd_word = SYSID_VALUE;
      3'd1: rd_word = TIMESTAMP;
      3'd2: rd_word = cnt[31:0];
      3'd3: rd_word = hi_word;
      3'd4: rd_word = scratch0;
      3'd5: rd_word = scratch1;
      3'd6: rd_word = {31'd0, run};
      3'd7: rd_word = {16'h0, 5'd0, 3'(READ_LATENCY), 8'(CNT_W)};
      default: rd_word = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      snap     <= '0;
      scratch0 <= '0;
      scratch1 <= '0;
      run      <= 1'b1;
    end else begin
      if (clear)
        cnt <= '0;
      else if (run)
        cnt <= cnt + CNT_W'(1);
      // Latch the high half on a low-word read so word 3 pairs with it.
      if (read && address == 3'd2)
        snap <= cnt[CNT_W-1:32];
      if (wr_en) begin
        for (int b = 0; b < 4; b++) begin
          if (byteenable[b]) begin
            if (address == 3'd4) scratch0[8*b +: 8] <= writedata[8*b +: 8];
            if (address == 3'd5) scratch1[8*b +: 8] <= writedata[8*b +: 8];
          end
        end
        if (address == 3'd6 && byteenable[0])
          run <= writedata[0];
      end
    end
  end

  // Stage 0 holds data sampled at the accept edge; idle slots carry zero.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_pipe <= '0;
      for (int i = 0; i < READ_LATENCY; i++)
        data_pipe[i] <= '0;
    end else begin
      valid_pipe[0] <= read;
      data_pipe[0]  <= read ? rd_word : 32'h0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        valid_pipe[i] <= valid_pipe[i-1];
        data_pipe[i]  <= data_pipe[i-1];
      end
    end
  end

  assign readdata      = data_pipe[READ_LATENCY-1];
  assign readdatavalid = valid_pipe[READ_LATENCY-1];
  assign uptime        = cnt;

endmodule

// File: tb/tb_sopc_sysid_ext.sv
// tb/tb_sopc_sysid_ext.sv - directed vector bench for sopc_sysid_ext at READ_LATENCY=2
module tb_sopc_sysid_ext;

  logic        clock;
  logic        reset_n;
  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;
  logic [63:0] uptime;

  int checks = 0;
  int errors = 0;

  sopc_sysid_ext #(
    .SYSID_VALUE (32'h0000_0000),
    .TIMESTAMP   (32'd1523851750),
    .READ_LATENCY(2),
    .CNT_W       (64)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid),
    .uptime       (uptime)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [3:0]  be;
    logic        ev;
    logic [31:0] ed;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic rd, logic wr, logic [2:0] addr, logic [31:0] wd,
                             logic [3:0] be, logic ev, logic [31:0] ed);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wd = wd; r.be = be; r.ev = ev; r.ed = ed;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic idle();
    read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'h0; byteenable = 4'h0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    idle();
    write = 1'b1; address = a; writedata = d; byteenable = be;
    cyc();
    idle();
  endtask

  // Issue one read and return its response after the two-cycle latency.
  task automatic do_read(input logic [2:0] a, output logic vld, output logic [31:0] d);
    idle();
    read = 1'b1; address = a;
    cyc();
    idle();
    cyc();
    vld = readdatavalid;
    d   = readdata;
  endtask

  logic        rv;
  logic [31:0] rdv;
  logic [31:0] first_rd;

  initial begin
    idle();
    reset_n = 1'b0;

    // Outputs of cycle k reflect the read issued in cycle k-2.
    tbl.push_back(v(1,0,3'd0,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(1,0,3'd1,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(1,0,3'd7,32'h0,4'h0,1,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'd1523851750));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h0000_0240));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,1,3'd4,32'hAABBCCDD,4'b0101,0,32'h0));
    tbl.push_back(v(1,0,3'd4,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h00BB00DD));
    tbl.push_back(v(0,1,3'd0,32'hFFFFFFFF,4'hF,0,32'h0));
    tbl.push_back(v(0,1,3'd1,32'hFFFFFFFF,4'hF,0,32'h0));
    tbl.push_back(v(1,0,3'd0,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(1,0,3'd1,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'd1523851750));
    tbl.push_back(v(0,1,3'd5,32'h12345678,4'hF,0,32'h0));
    tbl.push_back(v(1,1,3'd5,32'hCAFEBABE,4'hF,0,32'h0));
    tbl.push_back(v(1,0,3'd5,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h12345678));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h12345678));
    tbl.push_back(v(1,0,3'd6,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,1,3'd4,32'h11223344,4'b1010,0,32'h0));
    tbl.push_back(v(1,0,3'd4,32'h0,4'h0,1,32'h1));
    tbl.push_back(v(0,1,3'd6,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(1,0,3'd6,32'h0,4'h0,1,32'h11BB33DD));
    tbl.push_back(v(0,1,3'd7,32'hFFFFFFFF,4'hF,0,32'h0));
    tbl.push_back(v(1,0,3'd7,32'h0,4'h0,1,32'h1));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,0,32'h0));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,1,32'h0000_0240));
    tbl.push_back(v(0,0,3'd0,32'h0,4'h0,0,32'h0));

    repeat (3) @(negedge clock);
    chk("reset_valid", 64'(readdatavalid), 64'h0);
    chk("reset_data", 64'(readdata), 64'h0);
    chk("reset_uptime", uptime, 64'h0);
    reset_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      chk($sformatf("vec%0d_valid", i), 64'(readdatavalid), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_data", i), 64'(readdata), 64'(tbl[i].ed));
      read = tbl[i].rd; write = tbl[i].wr; address = tbl[i].addr;
      writedata = tbl[i].wd; byteenable = tbl[i].be;
      cyc();
    end
    idle();

    // Coherent 64-bit read across a low-word wrap.
    force dut.cnt = 64'h0000_0001_FFFF_FFFF;
    read = 1'b1; address = 3'd2;
    cyc();
    release dut.cnt;
    address = 3'd3;
    cyc();
    idle();
    chk("wrap_lo_valid", 64'(readdatavalid), 64'h1);
    chk("wrap_lo_data", 64'(readdata), 64'hFFFF_FFFF);
    cyc();
    chk("wrap_hi_valid", 64'(readdatavalid), 64'h1);
    chk("wrap_hi_data", 64'(readdata), 64'h1);
    cyc();

    // Clear with RUN kept on, then stop the counter.
    do_write(3'd6, 32'h3, 4'h1);
    repeat (10) cyc();
    do_read(3'd2, rv, rdv);
    chk("clear_valid", 64'(rv), 64'h1);
    chk("clear_count", 64'(rdv), 64'd10);
    do_write(3'd6, 32'h0, 4'h1);
    do_read(3'd2, rv, first_rd);
    chk("stop_first", 64'(first_rd), 64'd13);
    repeat (5) cyc();
    do_read(3'd2, rv, rdv);
    chk("stop_second", 64'(rdv), 64'(first_rd));
    chk("stop_uptime", uptime, 64'd13);

    // Reset one cycle after a read is accepted.
    read = 1'b1; address = 3'd4;
    cyc();
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_valid", 64'(readdatavalid), 64'h0);
    chk("midrst_uptime", uptime, 64'h0);
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk($sformatf("postrst_valid%0d", i), 64'(readdatavalid), 64'h0);
    end
    do_read(3'd4, rv, rdv);
    chk("postrst_scratch0", 64'(rdv), 64'h0);
    do_read(3'd6, rv, rdv);
    chk("postrst_run", 64'(rdv), 64'h1);
    do_read(3'd3, rv, rdv);
    chk("postrst_snap", 64'(rdv), 64'h0);
    do_read(3'd5, rv, rdv);
    chk("postrst_scratch1", 64'(rdv), 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
